// File: rtl/reservoir_input_serializer.sv
// rtl/reservoir_input_serializer.sv - signed sample to unary +/-1 step pulses with shadow cell sum
// Optional SER_SAT_STOP_EN: end a sample early once the shadow sum sits at the bound in its direction.
module reservoir_input_serializer #(
  parameter int DATA_WIDTH = 3,
  parameter int SAMPLE_W   = 4,
  parameter int MAX_STEPS  = 7
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iValid,
  output logic                         oReady,
  input  logic signed [SAMPLE_W-1:0]   iSample,
  input  logic                         iClear,
  output logic                         oBitU,
  output logic                         oEn,
  output logic                         oBusy,
  output logic                         oDone,
  output logic signed [DATA_WIDTH-1:0] oShadow
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t                       state, stateNext;
  logic   [CNT_W-1:0]           cnt, cntNext;
  logic                         dir, dirNext;
  logic signed [DATA_WIDTH-1:0] shadow;
  logic   [SAMPLE_W-1:0]        mag;
  logic   [CNT_W-1:0]           startCnt;
  logic                         accept, satStop, step;

  // Magnitude kept unsigned so the most negative sample maps to 2^(SAMPLE_W-1).
  assign mag      = iSample[SAMPLE_W-1] ? SAMPLE_W'(-iSample) : iSample;
  assign startCnt = (32'(mag) > MAX_STEPS) ? CNT_W'(MAX_STEPS) : CNT_W'(mag);
  assign accept   = iValid && (state == IDLE);

`ifdef SER_SAT_STOP_EN
  logic atBound;
  assign atBound = dir ? (shadow == SAT_MAX) : (shadow == SAT_MIN);
  assign satStop = (state == EMIT) && atBound;
`else
  assign satStop = 1'b0;
`endif

  assign step = (state == EMIT) && !satStop;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      dir   <= dirNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    dirNext   = dir;
    case (state)
      IDLE: begin
        if (accept) begin
          dirNext   = !iSample[SAMPLE_W-1];
          cntNext   = startCnt;
          stateNext = (startCnt == '0) ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (satStop) begin
          cntNext   = '0;
          stateNext = DONE;
        end else begin
          cntNext = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oReady = (state == IDLE);
    oBusy  = (state != IDLE);
    oDone  = (state == DONE);
    oEn    = step;
    oBitU  = (state == EMIT) && dir;
  end

  // Shadow mirrors the cell: saturate symmetrically, clear wins over a coincident step.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      shadow <= '0;
    end else if (iClear) begin
      shadow <= '0;
    end else if (step) begin
      if (dir && (shadow != SAT_MAX)) begin
        shadow <= shadow + ONE;
      end else if (!dir && (shadow != SAT_MIN)) begin
        shadow <= shadow - ONE;
      end
    end
  end

  assign oShadow = shadow;

endmodule

// File: tb/tb_reservoir_input_serializer.sv
// tb/tb_reservoir_input_serializer.sv - scoreboard bench for reservoir_input_serializer
// Expected per-cycle outputs are queued at each accept and popped on the falling edge.
module tb_reservoir_input_serializer;

  logic              iClk = 1'b0;
  logic              iRst, iValid, iClear;
  logic signed [3:0] iSample;
  logic              oReady, oBitU, oEn, oBusy, oDone;
  logic signed [2:0] oShadow;

  reservoir_input_serializer #(.DATA_WIDTH(3), .SAMPLE_W(4), .MAX_STEPS(7)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iSample(iSample),
    .iClear(iClear), .oBitU(oBitU), .oEn(oEn), .oBusy(oBusy), .oDone(oDone), .oShadow(oShadow)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic en;
    logic bitu;
    logic done;
    logic ready;
    int   sh;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mShadow = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int stepSh(input int s, input bit d);
    if (d) return (s == 3) ? 3 : s + 1;
    return (s == -3) ? -3 : s - 1;
  endfunction

  // Cycle-by-cycle expectation: pulses (or a dead saturated EMIT cycle), DONE, then IDLE.
  task automatic plan(input int s, input int clearAt);
    int n;
    bit d;
    int cur;
    n   = (s < 0) ? -s : s;
    d   = (s >= 0);
    cur = mShadow;
    if (n > 7) n = 7;
    for (int k = 0; k < n; k++) begin
`ifdef SER_SAT_STOP_EN
      if ((d && cur == 3) || (!d && cur == -3)) begin
        q.push_back('{en: 1'b0, bitu: d, done: 1'b0, ready: 1'b0, sh: cur});
        break;
      end
`endif
      q.push_back('{en: 1'b1, bitu: d, done: 1'b0, ready: 1'b0, sh: cur});
      cur = (k == clearAt) ? 0 : stepSh(cur, d);
    end
    q.push_back('{en: 1'b0, bitu: 1'b0, done: 1'b1, ready: 1'b0, sh: cur});
    q.push_back('{en: 1'b0, bitu: 1'b0, done: 1'b0, ready: 1'b1, sh: cur});
    mShadow = cur;
  endtask

  always @(negedge iClk) begin : monitor
    rec_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("oEn", oEn, r.en);
      chk("oBitU", oBitU, r.bitu);
      chk("oDone", oDone, r.done);
      chk("oReady", oReady, r.ready);
      chk("oBusy", oBusy, !r.ready);
      chk("oShadow", oShadow, r.sh);
    end
  end

  task automatic sendSample(input int s, input bit hold, input int clearAt);
    int cyc;
    cyc     = 0;
    iValid  = 1'b1;
    iSample = 4'(s);
    @(posedge iClk);
    #1;
    if (!hold) iValid = 1'b0;
    plan(s, clearAt);
    while (q.size() > 0 && cyc < 40) begin
      @(negedge iClk);
      #1;
      cyc++;
      iClear = (cyc == clearAt + 1);
      if (hold) iSample = 4'($urandom);
    end
    iClear = 1'b0;
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b1; iValid = 1'b0; iClear = 1'b0; iSample = '0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;
    @(negedge iClk);
    chk("rst_oReady", oReady, 1);
    chk("rst_oEn", oEn, 0);
    chk("rst_oBitU", oBitU, 0);
    chk("rst_oBusy", oBusy, 0);
    chk("rst_oDone", oDone, 0);
    chk("rst_oShadow", oShadow, 0);
    #1;

    sendSample(3, 1'b0, -1);
    sendSample(0, 1'b0, -1);

    iClear = 1'b1;
    @(posedge iClk);
    #1;
    iClear = 1'b0;
    mShadow = 0;
    chk("idle_clear_oShadow", oShadow, 0);
    chk("idle_clear_oEn", oEn, 0);

    sendSample(-8, 1'b0, -1);
    sendSample(3, 1'b0, -1);
    sendSample(3, 1'b0, 1);
    sendSample(2, 1'b1, -1);
    sendSample(-1, 1'b0, -1);
    sendSample(-7, 1'b0, -1);
    sendSample(2, 1'b0, -1);

    // Reset during the second pulse of +5.
    iValid = 1'b1; iSample = 4'sd5;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    @(negedge iClk);
    chk("abort_pulse1", oEn, 1);
    @(negedge iClk);
    chk("abort_pulse2", oEn, 1);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    mShadow = 0;
    chk("abort_oEn", oEn, 0);
    chk("abort_oShadow", oShadow, 0);
    chk("abort_oReady", oReady, 1);
    chk("abort_oDone", oDone, 0);
    chk("abort_oBusy", oBusy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk("abort_no_oDone", oDone, 0);
      chk("abort_no_oEn", oEn, 0);
    end
    #1;

    sendSample(1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
